// File: rtl/usb_ep_ctrl_pkg.sv
// Shared types and widths for the USB bulk endpoint controller.
package usb_pkg;

    localparam int RX_PKT_W = 3;
    localparam int TX_PKT_W = 3;
    localparam int OCC_W    = 7;

    typedef enum logic [RX_PKT_W-1:0] {
        RX_IDLE  = 3'd0,
        RX_IN    = 3'd1,
        RX_OUT   = 3'd2,
        RX_DATA0 = 3'd3,
        RX_DATA1 = 3'd4,
        RX_DONE  = 3'd5,
        RX_ACK   = 3'd6,
        RX_ERROR = 3'd7
    } rx_packet_t;

    typedef enum logic [TX_PKT_W-1:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4,
        TX_STALL = 3'd5
    } tx_packet_t;

    typedef enum logic [2:0] {
        IDLE, OUT_WAIT, OUT_RCV, OUT_RSP, IN_CHK, IN_NAK, IN_SEND, IN_ACKW
    } ep_state_t;

endpackage

// File: rtl/usb_ep_ctrl_timer.sv
// Saturating response timer; expired stays high once TIMEOUT_CYCLES enabled cycles have elapsed.
module usb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/usb_ep_ctrl.sv
// Bulk endpoint protocol controller: OUT payload steering, handshakes, IN data toggle and timeouts.
// Optional macro USB_EP_STALL_EN adds the ep_halt input and STALL responses.
module usb_ep_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_PACKET     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [RX_PKT_W-1:0] rx_packet,
    input  logic                store_rx_packet_data,
    input  logic [OCC_W-1:0]    buffer_occupancy,
    input  logic                tx_done,
`ifdef USB_EP_STALL_EN
    input  logic                ep_halt,
`endif
    output logic [TX_PKT_W-1:0] tx_packet,
    output logic                tx_start,
    output logic                store_rx_data,
    output logic                clear_buffer,
    output logic                rx_data_ready,
    output logic                rx_error,
    output logic                tx_error,
    output logic                d_mode
);

    localparam logic [OCC_W-1:0] MAX_CNT = OCC_W'(MAX_PACKET);

    logic halt;
`ifdef USB_EP_STALL_EN
    assign halt = ep_halt;
`else
    assign halt = 1'b0;
`endif

    ep_state_t           state_q, state_d;
    logic [RX_PKT_W-1:0] rx_q;
    logic                evt_q;
    logic [OCC_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d, stall_q, stall_d, toggle_q, toggle_d;
    tx_packet_t          tx_packet_q, tx_packet_d;
    logic                tx_start_q, tx_start_d, push_q, push_d, clear_q, clear_d;
    logic                rdy_q, rdy_d, rx_err_q, rx_err_d, tx_err_q, tx_err_d;
    logic                d_mode_q, d_mode_d;
    logic                expired;
    logic [OCC_W:0]      fill;
    rx_packet_t          code;

    usb_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (state_d != state_q),
        .enable (state_q == OUT_WAIT || state_q == IN_ACKW),
        .expired(expired)
    );

    // An event is a change of rx_packet; rx_q already holds the new code when evt_q is seen.
    assign code = rx_packet_t'(rx_q);
    assign fill = {1'b0, buffer_occupancy} + {1'b0, count_q};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        stall_d     = stall_q;
        toggle_d    = toggle_q;
        tx_packet_d = tx_packet_q;
        d_mode_d    = d_mode_q;
        tx_start_d  = 1'b0;
        push_d      = 1'b0;
        clear_d     = 1'b0;
        rdy_d       = 1'b0;
        rx_err_d    = 1'b0;
        tx_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (evt_q && code == RX_IN) begin
                    if (halt) begin
                        tx_start_d  = 1'b1;
                        d_mode_d    = 1'b1;
                        tx_packet_d = TX_STALL;
                        state_d     = IN_NAK;
                    end else begin
                        state_d = IN_CHK;
                    end
                end else if (evt_q && code == RX_OUT) begin
                    state_d = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (evt_q && (code == RX_DATA0 || code == RX_DATA1)) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    stall_d = 1'b0;
                    state_d = OUT_RCV;
                end else if (evt_q || expired) begin
                    rx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            OUT_RCV: begin
                if (store_rx_packet_data) begin
                    if (count_q == MAX_CNT || fill >= {1'b0, MAX_CNT})
                        ovf_d = 1'b1;
                    else
                        push_d = !halt;
                    if (count_q != MAX_CNT)
                        count_d = count_q + 1'b1;
                end
                // ovf_d already includes a byte strobed alongside DONE.
                if (evt_q && code == RX_DONE) begin
                    tx_start_d = 1'b1;
                    d_mode_d   = 1'b1;
                    state_d    = OUT_RSP;
                    if (halt) begin
                        tx_packet_d = TX_STALL;
                        stall_d     = 1'b1;
                    end else if (ovf_d) begin
                        tx_packet_d = TX_NAK;
                        clear_d     = 1'b1;
                    end else begin
                        tx_packet_d = TX_ACK;
                    end
                end else if (evt_q && code == RX_ERROR) begin
                    rx_err_d = 1'b1;
                    clear_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            OUT_RSP: begin
                if (tx_done) begin
                    d_mode_d    = 1'b0;
                    tx_packet_d = TX_NONE;
                    rdy_d       = !ovf_q && !stall_q;
                    state_d     = IDLE;
                end
            end
            IN_CHK: begin
                tx_start_d = 1'b1;
                d_mode_d   = 1'b1;
                if (buffer_occupancy == '0) begin
                    tx_packet_d = TX_NAK;
                    state_d     = IN_NAK;
                end else begin
                    tx_packet_d = toggle_q ? TX_DATA1 : TX_DATA0;
                    state_d     = IN_SEND;
                end
            end
            IN_NAK, IN_SEND: begin
                if (tx_done) begin
                    d_mode_d    = 1'b0;
                    tx_packet_d = TX_NONE;
                    state_d     = (state_q == IN_SEND) ? IN_ACKW : IDLE;
                end
            end
            IN_ACKW: begin
                if (evt_q && code == RX_ACK) begin
                    toggle_d = !toggle_q;
                    state_d  = IDLE;
                end else if ((evt_q && code == RX_ERROR) || expired) begin
                    tx_err_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            rx_q        <= '0;
            evt_q       <= 1'b0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            stall_q     <= 1'b0;
            toggle_q    <= 1'b0;
            tx_packet_q <= TX_NONE;
            d_mode_q    <= 1'b0;
            tx_start_q  <= 1'b0;
            push_q      <= 1'b0;
            clear_q     <= 1'b0;
            rdy_q       <= 1'b0;
            rx_err_q    <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_packet;
            evt_q       <= (rx_packet != rx_q);
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            stall_q     <= stall_d;
            toggle_q    <= toggle_d;
            tx_packet_q <= tx_packet_d;
            d_mode_q    <= d_mode_d;
            tx_start_q  <= tx_start_d;
            push_q      <= push_d;
            clear_q     <= clear_d;
            rdy_q       <= rdy_d;
            rx_err_q    <= rx_err_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign tx_packet     = tx_packet_q;
    assign tx_start      = tx_start_q;
    assign store_rx_data = push_q;
    assign clear_buffer  = clear_q;
    assign rx_data_ready = rdy_q;
    assign rx_error      = rx_err_q;
    assign tx_error      = tx_err_q;
    assign d_mode        = d_mode_q;

endmodule

// File: tb/tb_usb_ep_ctrl.sv
// Scoreboard bench for usb_ep_ctrl: directed transactions queue expected output records; a monitor checks them.
module tb_usb_ep_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] rx_packet = 3'd0;
    logic       store_rx_packet_data = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       tx_done = 1'b0;
    logic [2:0] tx_packet;
    logic       tx_start, store_rx_data, clear_buffer, rx_data_ready;
    logic       rx_error, tx_error, d_mode;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_q[$];

    usb_ep_ctrl dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .rx_packet           (rx_packet),
        .store_rx_packet_data(store_rx_packet_data),
        .buffer_occupancy    (buffer_occupancy),
        .tx_done             (tx_done),
`ifdef USB_EP_STALL_EN
        .ep_halt             (1'b0),
`endif
        .tx_packet           (tx_packet),
        .tx_start            (tx_start),
        .store_rx_data       (store_rx_data),
        .clear_buffer        (clear_buffer),
        .rx_data_ready       (rx_data_ready),
        .rx_error            (rx_error),
        .tx_error            (tx_error),
        .d_mode              (d_mode)
    );

    always #5 clk = ~clk;

    // Record layout: {tx_start, tx_packet[2:0], push, clear, ready, rx_err, tx_err, d_mode}
    function automatic logic [9:0] mk(input logic st, input logic [2:0] pkt, input logic psh,
                                      input logic clr, input logic rdy, input logic rxe,
                                      input logic txe, input logic dm);
        return {st, pkt, psh, clr, rdy, rxe, txe, dm};
    endfunction

    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] exp;
        if (n_rst && (tx_start || store_rx_data || clear_buffer || rx_data_ready || rx_error || tx_error)) begin
            act = mk(tx_start, tx_packet, store_rx_data, clear_buffer, rx_data_ready, rx_error, tx_error, d_mode);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got %b, required nothing", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL output_record @%0t: got %b, required %b", $time, act, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input logic [2:0] c, input int hold);
        rx_packet = c;
        repeat (hold) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        check(name, {tx_start, tx_packet, store_rx_data, clear_buffer, rx_data_ready,
                     rx_error, tx_error, d_mode}, 32'd0);
    endtask

    // sel 0 waits for tx_start, sel 1 for tx_error; an expired budget is a failure.
    task automatic wait_for(input int sel, input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if ((sel == 0 && tx_start) || (sel == 1 && tx_error)) seen = 1;
            else tick();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s: got no pulse within %0d cycles, required a pulse", name, budget);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check_idle_outputs("reset_outputs_held");
        n_rst = 1'b1;
        tick();
        check_idle_outputs("reset_outputs_after_release");

        // OUT / DATA0 / 4 bytes, last byte strobed alongside the DONE event -> ACK
        buffer_occupancy = 7'd0;
        set_rx(3'd2, 3);
        set_rx(3'd3, 3);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(0, 3'd0, 1, 0, 0, 0, 0, 0));
            store_rx_packet_data = 1'b1;
            tick();
            store_rx_packet_data = 1'b0;
            tick();
        end
        exp_q.push_back(mk(1, 3'd3, 1, 0, 0, 0, 0, 1));
        rx_packet = 3'd5;
        tick();
        store_rx_packet_data = 1'b1;
        tick();
        store_rx_packet_data = 1'b0;
        wait_for(0, 20, "out_ack_start");
        repeat (2) tick();
        exp_q.push_back(mk(0, 3'd0, 0, 0, 1, 0, 0, 0));
        pulse_done();
        set_rx(3'd0, 3);

        // OUT / DATA1 / 65 bytes -> 64 pushes, NAK with buffer flush
        set_rx(3'd2, 3);
        set_rx(3'd4, 3);
        for (int i = 0; i < 64; i++) exp_q.push_back(mk(0, 3'd0, 1, 0, 0, 0, 0, 0));
        store_rx_packet_data = 1'b1;
        repeat (65) tick();
        store_rx_packet_data = 1'b0;
        tick();
        exp_q.push_back(mk(1, 3'd4, 0, 1, 0, 0, 0, 1));
        set_rx(3'd5, 1);
        wait_for(0, 20, "out_nak_start");
        repeat (2) tick();
        pulse_done();
        set_rx(3'd0, 3);

        // IN with empty buffer -> NAK, d_mode held until tx_done
        exp_q.push_back(mk(1, 3'd4, 0, 0, 0, 0, 0, 1));
        set_rx(3'd1, 1);
        wait_for(0, 20, "in_nak_start");
        for (int i = 0; i < 3; i++) begin
            check("in_nak_d_mode_held", d_mode, 1);
            tick();
        end
        pulse_done();
        check("in_nak_d_mode_released", d_mode, 0);
        set_rx(3'd0, 3);

        // IN/ACK twice -> DATA0 then DATA1
        buffer_occupancy = 7'd8;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(1, (k == 0) ? 3'd1 : 3'd2, 0, 0, 0, 0, 0, 1));
            set_rx(3'd1, 1);
            wait_for(0, 20, "in_data_start");
            tick();
            pulse_done();
            set_rx(3'd6, 3);
            set_rx(3'd0, 3);
        end

        // IN with no ACK -> tx_error after timeout; retry resends DATA0
        exp_q.push_back(mk(1, 3'd1, 0, 0, 0, 0, 0, 1));
        set_rx(3'd1, 1);
        wait_for(0, 20, "in_timeout_start");
        tick();
        exp_q.push_back(mk(0, 3'd0, 0, 0, 0, 0, 1, 0));
        pulse_done();
        wait_for(1, 1200, "in_timeout_tx_error");
        tick();
        set_rx(3'd0, 3);
        exp_q.push_back(mk(1, 3'd1, 0, 0, 0, 0, 0, 1));
        set_rx(3'd1, 1);
        wait_for(0, 20, "in_retry_start");
        tick();
        pulse_done();
        set_rx(3'd6, 3);
        set_rx(3'd0, 3);

        // OUT / DATA0 / 2 bytes / ERROR -> rx_error with flush, no handshake
        buffer_occupancy = 7'd0;
        set_rx(3'd2, 3);
        set_rx(3'd3, 3);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mk(0, 3'd0, 1, 0, 0, 0, 0, 0));
            store_rx_packet_data = 1'b1;
            tick();
            store_rx_packet_data = 1'b0;
            tick();
        end
        exp_q.push_back(mk(0, 3'd0, 0, 1, 0, 1, 0, 0));
        set_rx(3'd7, 5);

        // Reset while a push strobe is high in OUT_RCV
        set_rx(3'd2, 3);
        set_rx(3'd3, 3);
        exp_q.push_back(mk(0, 3'd0, 1, 0, 0, 0, 0, 0));
        store_rx_packet_data = 1'b1;
        tick();
        store_rx_packet_data = 1'b0;
        tick();
        store_rx_packet_data = 1'b1;
        tick();
        store_rx_packet_data = 1'b0;
        check("push_before_reset", store_rx_data, 1);
        n_rst = 1'b0;
        #1;
        check_idle_outputs("async_reset_mid_out");
        rx_packet = 3'd0;
        tick();
        n_rst = 1'b1;
        repeat (5) tick();
        check_idle_outputs("idle_after_reset");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
